// File: rtl/avst_pkt_monitor.sv
// Passive multi-channel Avalon-ST frame checker: framing, runt/giant and error
// statistics per stream, with sticky flags and saturating packet counters.
module avst_pkt_monitor #(
   parameter int N_CH    = 2,
   parameter int DATA_W  = 32,
   parameter int EMPTY_W = 2,
   parameter int ERR_W   = 6,
   parameter int CNT_W   = 32,
   parameter int LEN_W   = 16,
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
) (
   input  logic                     sys_clk,
   input  logic                     reset_n,
   input  logic                     clear,
   input  logic [N_CH-1:0]          mon_valid,
   input  logic [N_CH-1:0]          mon_ready,
   input  logic [N_CH-1:0]          mon_sop,
   input  logic [N_CH-1:0]          mon_eop,
   input  logic [N_CH*EMPTY_W-1:0]  mon_empty,
   input  logic [N_CH*ERR_W-1:0]    mon_error,
   output logic [N_CH*6-1:0]        sticky_err,
   output logic [N_CH*CNT_W-1:0]    pkt_count,
   output logic [N_CH*CNT_W-1:0]    err_pkt_count,
   output logic [N_CH*LEN_W-1:0]    last_len,
   output logic                     any_err
);

   localparam int BYTES = DATA_W / 8;
   localparam logic [LEN_W:0]   BYTES_X = (LEN_W+1)'(BYTES);
   localparam logic [LEN_W-1:0] LEN_SAT = '1;
   localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
   localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] CNT_SAT = '1;

   typedef enum logic {IDLE, IN_PKT} state_t;

   logic [N_CH*6-1:0] flags_nxt_all;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic               beat, sop, eop;
      logic [EMPTY_W-1:0] empty;
      logic [ERR_W-1:0]   err;
      state_t             state, state_nxt;
      logic [LEN_W-1:0]   len, len_nxt;
      logic               mark, mark_nxt;
      logic [5:0]         flags, flags_nxt, flags_ev;
      logic [CNT_W-1:0]   pkt_cnt, pkt_cnt_nxt, pkt_base;
      logic [CNT_W-1:0]   err_cnt, err_cnt_nxt, err_base;
      logic [LEN_W-1:0]   last, last_nxt;
      logic [LEN_W:0]     beat_bytes, sum;
      logic [LEN_W-1:0]   new_len;
      logic               beat_bad, done, runt, giant, pkt_bad;

      assign beat  = mon_valid[c] & mon_ready[c];
      assign sop   = mon_sop[c];
      assign eop   = mon_eop[c];
      assign empty = mon_empty[c*EMPTY_W +: EMPTY_W];
      assign err   = mon_error[c*ERR_W +: ERR_W];

      always_comb begin
         beat_bytes = eop ? BYTES_X - (LEN_W+1)'(empty) : BYTES_X;
         beat_bad   = (err != '0) | ((empty != '0) & ~eop);
         // A sop beat restarts the accumulator, so the old length is dropped
         sum        = (sop ? '0 : {1'b0, len}) + beat_bytes;
         new_len    = sum[LEN_W] ? LEN_SAT : sum[LEN_W-1:0];
         runt       = new_len < MIN_L;
         giant      = new_len > MAX_L;

         state_nxt = state;
         len_nxt   = len;
         mark_nxt  = mark;
         done      = 1'b0;
         flags_ev  = '0;
         if (beat) begin
            flags_ev[0] = err != '0;
            flags_ev[1] = (empty != '0) & ~eop;
            if (!sop && state == IDLE) begin
               flags_ev[2] = 1'b1;
            end else begin
               flags_ev[3] = sop & (state == IN_PKT);
               len_nxt     = new_len;
               mark_nxt    = (sop ? 1'b0 : mark) | beat_bad;
               if (eop) begin
                  done      = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = IN_PKT;
               end
            end
         end
         pkt_bad = mark_nxt | runt | giant;
         if (done) begin
            flags_ev[4] = runt;
            flags_ev[5] = giant;
         end

         // clear zeroes the statistics first; same-cycle events land on top
         flags_nxt   = (clear ? '0 : flags) | flags_ev;
         pkt_base    = clear ? '0 : pkt_cnt;
         err_base    = clear ? '0 : err_cnt;
         last_nxt    = clear ? '0 : last;
         pkt_cnt_nxt = pkt_base;
         err_cnt_nxt = err_base;
         if (done) begin
            last_nxt = new_len;
            if (pkt_bad) begin
               if (err_base != CNT_SAT) err_cnt_nxt = err_base + CNT_W'(1);
            end else begin
               if (pkt_base != CNT_SAT) pkt_cnt_nxt = pkt_base + CNT_W'(1);
            end
         end
      end

      always_ff @(posedge sys_clk or negedge reset_n) begin
         if (!reset_n) begin
            state   <= IDLE;
            len     <= '0;
            mark    <= 1'b0;
            flags   <= '0;
            pkt_cnt <= '0;
            err_cnt <= '0;
            last    <= '0;
         end else begin
            state   <= state_nxt;
            len     <= len_nxt;
            mark    <= mark_nxt;
            flags   <= flags_nxt;
            pkt_cnt <= pkt_cnt_nxt;
            err_cnt <= err_cnt_nxt;
            last    <= last_nxt;
         end
      end

      assign flags_nxt_all[c*6 +: 6]        = flags_nxt;
      assign sticky_err[c*6 +: 6]           = flags;
      assign pkt_count[c*CNT_W +: CNT_W]    = pkt_cnt;
      assign err_pkt_count[c*CNT_W +: CNT_W] = err_cnt;
      assign last_len[c*LEN_W +: LEN_W]     = last;
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         any_err <= 1'b0;
      end else begin
         any_err <= |flags_nxt_all;
      end
   end

endmodule

// File: tb/tb_avst_pkt_monitor.sv
// Directed plus randomized check of avst_pkt_monitor against a packet-level model.
module tb_avst_pkt_monitor;

   localparam int N_CH    = 2;
   localparam int EMPTY_W = 2;
   localparam int ERR_W   = 6;
   localparam int CNT_W   = 32;
   localparam int LEN_W   = 16;
   localparam int BYTES   = 4;
   localparam int MIN_LEN = 64;
   localparam int MAX_LEN = 1518;
   localparam int LEN_MAX = 65535;

   logic                    sys_clk = 1'b0;
   logic                    reset_n;
   logic                    clear;
   logic [N_CH-1:0]         mon_valid, mon_ready, mon_sop, mon_eop;
   logic [N_CH*EMPTY_W-1:0] mon_empty;
   logic [N_CH*ERR_W-1:0]   mon_error;
   logic [N_CH*6-1:0]       sticky_err;
   logic [N_CH*CNT_W-1:0]   pkt_count, err_pkt_count;
   logic [N_CH*LEN_W-1:0]   last_len;
   logic                    any_err;

   int total = 0;
   int bad   = 0;

   // reference model state, per channel
   int         m_inpkt[N_CH];
   int         m_len[N_CH];
   int         m_mark[N_CH];
   logic [5:0] m_flags[N_CH];
   longint     m_pkt[N_CH];
   longint     m_err[N_CH];
   int         m_last[N_CH];

   avst_pkt_monitor #(
      .N_CH(N_CH), .DATA_W(32), .EMPTY_W(EMPTY_W), .ERR_W(ERR_W), .CNT_W(CNT_W),
      .LEN_W(LEN_W), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)
   ) dut (
      .sys_clk(sys_clk), .reset_n(reset_n), .clear(clear),
      .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_sop(mon_sop), .mon_eop(mon_eop),
      .mon_empty(mon_empty), .mon_error(mon_error),
      .sticky_err(sticky_err), .pkt_count(pkt_count), .err_pkt_count(err_pkt_count),
      .last_len(last_len), .any_err(any_err)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_inpkt[c] = 0; m_len[c] = 0; m_mark[c] = 0; m_flags[c] = '0;
         m_pkt[c] = 0; m_err[c] = 0; m_last[c] = 0;
      end
   endtask

   task automatic complete(input int c);
      int runt, giant;
      runt  = (m_len[c] < MIN_LEN) ? 1 : 0;
      giant = (m_len[c] > MAX_LEN) ? 1 : 0;
      if (runt != 0)  m_flags[c][4] = 1'b1;
      if (giant != 0) m_flags[c][5] = 1'b1;
      m_last[c] = m_len[c];
      if (m_mark[c] != 0 || runt != 0 || giant != 0) begin
         if (m_err[c] < 64'hFFFF_FFFF) m_err[c]++;
      end else begin
         if (m_pkt[c] < 64'hFFFF_FFFF) m_pkt[c]++;
      end
      m_inpkt[c] = 0;
   endtask

   task automatic model_cycle();
      if (clear) begin
         for (int c = 0; c < N_CH; c++) begin
            m_flags[c] = '0; m_pkt[c] = 0; m_err[c] = 0; m_last[c] = 0;
         end
      end
      for (int c = 0; c < N_CH; c++) begin
         int emp, errv, nbytes, beat_bad;
         if (!(mon_valid[c] && mon_ready[c])) continue;
         emp    = int'(mon_empty[c*EMPTY_W +: EMPTY_W]);
         errv   = int'(mon_error[c*ERR_W +: ERR_W]);
         nbytes = mon_eop[c] ? BYTES - emp : BYTES;
         beat_bad = 0;
         if (errv != 0) begin m_flags[c][0] = 1'b1; beat_bad = 1; end
         if (emp != 0 && !mon_eop[c]) begin m_flags[c][1] = 1'b1; beat_bad = 1; end
         if (mon_sop[c]) begin
            if (m_inpkt[c] != 0) m_flags[c][3] = 1'b1;
            m_inpkt[c] = 1; m_len[c] = 0; m_mark[c] = 0;
         end else if (m_inpkt[c] == 0) begin
            m_flags[c][2] = 1'b1;
            continue;
         end
         m_len[c] = (m_len[c] + nbytes > LEN_MAX) ? LEN_MAX : m_len[c] + nbytes;
         if (beat_bad != 0) m_mark[c] = 1;
         if (mon_eop[c]) complete(c);
      end
   endtask

   task automatic check_model();
      logic any;
      any = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
         chk($sformatf("ch%0d_sticky", c), 32'(sticky_err[c*6 +: 6]), 32'(m_flags[c]));
         chk($sformatf("ch%0d_pkt_count", c), pkt_count[c*CNT_W +: CNT_W], 32'(m_pkt[c]));
         chk($sformatf("ch%0d_err_pkt_count", c), err_pkt_count[c*CNT_W +: CNT_W], 32'(m_err[c]));
         chk($sformatf("ch%0d_last_len", c), 32'(last_len[c*LEN_W +: LEN_W]), 32'(m_last[c]));
         any = any | (|m_flags[c]);
      end
      chk("any_err", 32'(any_err), 32'(any));
   endtask

   task automatic idle_inputs();
      mon_valid = '0; mon_ready = '0; mon_sop = '0; mon_eop = '0;
      mon_empty = '0; mon_error = '0; clear = 1'b0;
   endtask

   task automatic set_ch(input int c, input logic v, input logic r, input logic s,
                         input logic e, input int emp, input int err);
      mon_valid[c] = v; mon_ready[c] = r; mon_sop[c] = s; mon_eop[c] = e;
      mon_empty[c*EMPTY_W +: EMPTY_W] = EMPTY_W'(emp);
      mon_error[c*ERR_W +: ERR_W]     = ERR_W'(err);
   endtask

   task automatic step();
      @(posedge sys_clk);
      model_cycle();
      #1;
      check_model();
   endtask

   task automatic send_pkt(input int c, input int nbeats, input int last_empty, input logic clr_on_eop);
      for (int i = 0; i < nbeats; i++) begin
         idle_inputs();
         set_ch(c, 1'b1, 1'b1, i == 0, i == nbeats - 1, (i == nbeats - 1) ? last_empty : 0, 0);
         if (i == nbeats - 1) clear = clr_on_eop;
         step();
      end
      idle_inputs();
   endtask

   task automatic send_open(input int c, input int nbeats);
      for (int i = 0; i < nbeats; i++) begin
         idle_inputs();
         set_ch(c, 1'b1, 1'b1, i == 0, 1'b0, 0, 0);
         step();
      end
      idle_inputs();
   endtask

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      model_reset();
      #12;
      check_model();
      chk("reset_sticky", 32'(sticky_err), 32'd0);
      chk("reset_any_err", 32'(any_err), 32'd0);
      reset_n = 1'b1;
      step();

      // ch0 runt: 15*4 + (4-2) = 62 bytes
      send_pkt(0, 16, 2, 1'b0);
      chk("runt_last_len", 32'(last_len[0 +: LEN_W]), 32'd62);
      chk("runt_flag", 32'(sticky_err[4]), 32'd1);
      chk("runt_err_cnt", err_pkt_count[0 +: CNT_W], 32'd1);
      chk("runt_pkt_cnt", pkt_count[0 +: CNT_W], 32'd0);
      step(); step();
      chk("runt_hold", 32'(last_len[0 +: LEN_W]), 32'd62);

      // ch1 giant then a good 400-byte packet
      send_pkt(1, 400, 0, 1'b0);
      chk("giant_last_len", 32'(last_len[LEN_W +: LEN_W]), 32'd1600);
      chk("giant_flag", 32'(sticky_err[6 + 5]), 32'd1);
      chk("giant_err_cnt", err_pkt_count[CNT_W +: CNT_W], 32'd1);
      send_pkt(1, 100, 0, 1'b0);
      chk("good_last_len", 32'(last_len[LEN_W +: LEN_W]), 32'd400);
      chk("good_pkt_cnt", pkt_count[CNT_W +: CNT_W], 32'd1);

      // ch0 nested sop: first packet abandoned, second completes at 80 bytes
      send_open(0, 20);
      send_pkt(0, 20, 0, 1'b0);
      chk("nested_flag", 32'(sticky_err[3]), 32'd1);
      chk("nested_last_len", 32'(last_len[0 +: LEN_W]), 32'd80);
      chk("nested_pkt_cnt", pkt_count[0 +: CNT_W], 32'd1);
      chk("nested_err_cnt", err_pkt_count[0 +: CNT_W], 32'd1);

      // valid without ready is not a beat, even with sop/eop
      idle_inputs(); set_ch(0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0); step();
      idle_inputs(); set_ch(0, 1'b1, 1'b0, 1'b0, 1'b1, 3, 5); step();
      idle_inputs(); set_ch(0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0); step();
      chk("noready_flag0", 32'(sticky_err[0]), 32'd0);
      chk("noready_pkt_cnt", pkt_count[0 +: CNT_W], 32'd1);
      idle_inputs(); set_ch(0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0); step();
      chk("outside_flag", 32'(sticky_err[2]), 32'd1);
      chk("outside_pkt_cnt", pkt_count[0 +: CNT_W], 32'd1);
      chk("outside_err_cnt", err_pkt_count[0 +: CNT_W], 32'd1);
      idle_inputs();

      // ch1 mid-packet empty and MAC error
      idle_inputs(); set_ch(1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0); step();
      idle_inputs(); set_ch(1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1); step();
      chk("midbad_flag0", 32'(sticky_err[6 + 0]), 32'd1);
      chk("midbad_flag1", 32'(sticky_err[6 + 1]), 32'd1);
      chk("midbad_any_err", 32'(any_err), 32'd1);
      for (int i = 0; i < 17; i++) begin
         idle_inputs(); set_ch(1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0); step();
      end
      idle_inputs(); set_ch(1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0); step();
      idle_inputs();
      chk("midbad_err_cnt", err_pkt_count[CNT_W +: CNT_W], 32'd2);
      chk("midbad_last_len", 32'(last_len[LEN_W +: LEN_W]), 32'd80);

      // clear together with a good completion
      send_pkt(0, 20, 0, 1'b1);
      chk("clr_pkt_cnt", pkt_count[0 +: CNT_W], 32'd1);
      chk("clr_err_cnt", err_pkt_count[0 +: CNT_W], 32'd0);
      chk("clr_sticky", 32'(sticky_err), 32'd0);
      chk("clr_any_err", 32'(any_err), 32'd0);
      chk("clr_ch1_err_cnt", err_pkt_count[CNT_W +: CNT_W], 32'd0);

      // reset mid-packet discards it
      send_open(0, 5);
      reset_n = 1'b0;
      model_reset();
      #2;
      check_model();
      reset_n = 1'b1;
      send_pkt(0, 17, 3, 1'b0);
      chk("rst_pkt_cnt", pkt_count[0 +: CNT_W], 32'd1);
      chk("rst_last_len", 32'(last_len[0 +: LEN_W]), 32'd65);
      chk("rst_no_nested", 32'(sticky_err[3]), 32'd0);

      // randomized traffic on both channels
      for (int k = 0; k < 3000; k++) begin
         idle_inputs();
         clear = ($urandom_range(0, 199) == 0);
         for (int c = 0; c < N_CH; c++) begin
            set_ch(c,
                   $urandom_range(0, 3) != 0,
                   $urandom_range(0, 4) != 0,
                   $urandom_range(0, 11) == 0,
                   $urandom_range(0, (c == 0) ? 11 : 40) == 0,
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : 0,
                   ($urandom_range(0, 29) == 0) ? int'($urandom_range(1, 63)) : 0);
         end
         step();
      end
      idle_inputs();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
